// File: rtl/apb_master_bridge_pkg.sv
// Shared types and constants for the valid/ready to APB3 master bridge.
package apb_pkg;

  localparam int unsigned APB_DATA_WIDTH     = 32;
  localparam int unsigned APB_ADDR_WIDTH_DEF = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic [APB_ADDR_WIDTH_DEF-1:0] addr;
    logic                          we;
    logic [APB_DATA_WIDTH-1:0]     wdata;
  } apb_req_t;

  typedef struct packed {
    logic [APB_DATA_WIDTH-1:0] rdata;
    logic                      err;
    logic                      timeout;
  } apb_resp_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Request/response port plus APB3 bus seen by the bridge (master) and its environment (slave).
interface apb_master_bridge_if
  import apb_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12
);

  logic                      req_valid;
  logic                      req_ready;
  logic [APB_ADDR_WIDTH-1:0] req_addr;
  logic                      req_we;
  logic [APB_DATA_WIDTH-1:0] req_wdata;

  logic                      resp_valid;
  logic                      resp_ready;
  logic [APB_DATA_WIDTH-1:0] resp_rdata;
  logic                      resp_err;
  logic                      resp_timeout;

  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [APB_DATA_WIDTH-1:0] PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [APB_DATA_WIDTH-1:0] PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    input  req_valid, req_addr, req_we, req_wdata, resp_ready,
           PRDATA, PREADY, PSLVERR,
    output req_ready, resp_valid, resp_rdata, resp_err, resp_timeout,
           PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );

  modport slave (
    output req_valid, req_addr, req_we, req_wdata, resp_ready,
           PRDATA, PREADY, PSLVERR,
    input  req_ready, resp_valid, resp_rdata, resp_err, resp_timeout,
           PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );

endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 master: one request in, one SETUP/ACCESS transfer out,
// one response back, with an optional PREADY timeout.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  apb_master_bridge_if.master bus
);

  localparam bit                   TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0
                                           : CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  apb_state_e                state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      req_ready_q, req_ready_d;
  logic                      resp_valid_q, resp_valid_d;
  apb_resp_t                 resp_q, resp_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;

  // Next state, captured payloads and the timeout counter.
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    resp_d   = resp_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          paddr_d  = bus.req_addr;
          pwrite_d = bus.req_we;
          if (bus.req_we) pwdata_d = bus.req_wdata;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (bus.PREADY) begin
          resp_d.rdata   = pwrite_q ? '0 : bus.PRDATA;
          resp_d.err     = bus.PSLVERR;
          resp_d.timeout = 1'b0;
          cnt_d          = '0;
          state_d        = RESP;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          resp_d.rdata   = '0;
          resp_d.err     = 1'b1;
          resp_d.timeout = 1'b1;
          cnt_d          = '0;
          state_d        = RESP;
        end else if (TO_EN && (cnt_q != '1)) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Bus/handshake flags are registered copies of the next-state decode.
    psel_d       = (state_d == SETUP) || (state_d == ACCESS);
    penable_d    = (state_d == ACCESS);
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= IDLE;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pwrite_q     <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      pwrite_q     <= pwrite_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_rdata   = resp_q.rdata;
  assign bus.resp_err     = resp_q.err;
  assign bus.resp_timeout = resp_q.timeout;
  assign bus.PADDR        = paddr_q;
  assign bus.PWDATA       = pwdata_q;
  assign bus.PWRITE       = pwrite_q;
  assign bus.PSEL         = psel_q;
  assign bus.PENABLE      = penable_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed and random transfers against a transaction-level model.
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned TO = 4;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  logic [31:0] last_wdata;

  apb_master_bridge_if #(.APB_ADDR_WIDTH(AW)) bus ();

  apb_master_bridge #(
    .APB_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO),
    .CNT_WIDTH     (8)
  ) dut (
    .HCLK   (clk),
    .HRESETn(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Transaction-level expectation: timeout iff the slave waits TO or more cycles.
  function automatic apb_resp_t model_resp(input bit we, input int waits, input bit err,
                                           input logic [31:0] prd);
    apb_resp_t r;
    if (waits >= int'(TO)) r = '{rdata: 32'h0, err: 1'b1, timeout: 1'b1};
    else                   r = '{rdata: (we ? 32'h0 : prd), err: err, timeout: 1'b0};
    return r;
  endfunction

  function automatic int model_access(input int waits);
    return (waits >= int'(TO)) ? int'(TO) : waits + 1;
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full transfer starting from IDLE at a negedge; slave inserts 'waits' wait states.
  task automatic do_xfer(input bit we, input logic [AW-1:0] addr, input logic [31:0] wdata,
                         input int waits, input bit err, input logic [31:0] prd, input int hold);
    apb_resp_t exp;
    int        access;
    exp = model_resp(we, waits, err, prd);
    if (we) last_wdata = wdata;

    chk("req_ready_idle", 32'(bus.req_ready), 32'h1);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_we    = we;
    bus.req_wdata = wdata;
    cyc();
    bus.req_valid  = 1'b0;
    bus.req_addr   = AW'($urandom);
    bus.req_we     = 1'($urandom);
    bus.req_wdata  = $urandom;
    bus.PREADY     = 1'($urandom);
    bus.PSLVERR    = 1'($urandom);
    bus.resp_ready = 1'($urandom);
    chk("setup_ctl", 32'({bus.PSEL, bus.PENABLE, bus.req_ready, bus.PWRITE, bus.PADDR}),
        32'({3'b100, we, addr}));
    chk("setup_pwdata", bus.PWDATA, last_wdata);
    cyc();

    access = 0;
    while (1) begin
      access++;
      chk("access_ctl", 32'({bus.PSEL, bus.PENABLE, bus.resp_valid, bus.PWRITE, bus.PADDR}),
          32'({3'b110, we, addr}));
      if (access - 1 == waits) begin
        bus.PREADY  = 1'b1;
        bus.PSLVERR = err;
        bus.PRDATA  = prd;
      end else begin
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'($urandom);
        bus.PRDATA  = $urandom;
      end
      cyc();
      bus.PREADY  = 1'($urandom);
      bus.PSLVERR = 1'($urandom);
      bus.PRDATA  = $urandom;
      if (bus.resp_valid || access >= 64) break;
    end
    bus.resp_ready = 1'b0;

    chk("access_cycles", 32'(access), 32'(model_access(waits)));
    chk("resp_rdata", bus.resp_rdata, exp.rdata);
    chk("resp_flags", 32'({bus.resp_valid, bus.resp_err, bus.resp_timeout}),
        32'({1'b1, exp.err, exp.timeout}));
    chk("resp_bus_idle", 32'({bus.PSEL, bus.PENABLE, bus.req_ready}), 32'h0);
    for (int i = 0; i < hold; i++) begin
      cyc();
      chk("resp_hold", 32'({bus.resp_valid, bus.resp_err, bus.resp_timeout, bus.PSEL}),
          32'({1'b1, exp.err, exp.timeout, 1'b0}));
      chk("resp_hold_rdata", bus.resp_rdata, exp.rdata);
    end
    bus.resp_ready = 1'b1;
    cyc();
    bus.resp_ready = 1'($urandom);
    chk("after_handshake", 32'({bus.resp_valid, bus.req_ready, bus.PSEL}), 32'b010);
  endtask

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    last_wdata   = 32'h0;
    rst_n        = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_we     = 1'b0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    bus.PRDATA     = '0;
    bus.PREADY     = 1'b0;
    bus.PSLVERR    = 1'b0;

    #12;
    chk("rst_ctl", 32'({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.resp_valid, bus.resp_err,
                        bus.resp_timeout, bus.req_ready}), 32'b0000001);
    chk("rst_paddr", 32'(bus.PADDR), 32'h0);
    chk("rst_pwdata", bus.PWDATA, 32'h0);
    chk("rst_rdata", bus.resp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Directed cases.
    do_xfer(1'b1, 12'h008, 32'hA5A5_0F0F, 0, 1'b0, 32'hDEAD_BEEF, 0);
    do_xfer(1'b0, 12'h004, 32'h1111_2222, 3, 1'b0, 32'h1234_5678, 1);
    do_xfer(1'b0, 12'h0FC, 32'h0, 0, 1'b1, 32'hCAFE_0001, 0);
    do_xfer(1'b0, 12'h100, 32'h0, 1000, 1'b0, 32'h5555_AAAA, 0);
    do_xfer(1'b0, 12'h104, 32'h0, int'(TO) - 1, 1'b0, 32'h0BAD_F00D, 0);
    do_xfer(1'b1, 12'h108, 32'h7777_8888, int'(TO), 1'b0, 32'h0, 2);

    // Backpressure: response held while a new request waits.
    bus.req_valid = 1'b1;
    bus.req_addr  = 12'h010;
    bus.req_we    = 1'b0;
    cyc();
    bus.PREADY = 1'b0;
    cyc();
    bus.PREADY  = 1'b1;
    bus.PSLVERR = 1'b0;
    bus.PRDATA  = 32'h3C3C_C3C3;
    bus.resp_ready = 1'b0;
    cyc();
    bus.req_addr  = 12'h020;
    bus.req_we    = 1'b1;
    bus.req_wdata = 32'h0F1E_2D3C;
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", 32'({bus.resp_valid, bus.req_ready, bus.PSEL, bus.resp_err}), 32'b1000);
      chk("bp_rdata", bus.resp_rdata, 32'h3C3C_C3C3);
      cyc();
    end
    bus.resp_ready = 1'b1;
    cyc();
    bus.resp_ready = 1'b0;
    chk("bp_idle_gap", 32'({bus.resp_valid, bus.req_ready, bus.PSEL}), 32'b010);
    cyc();
    bus.req_valid = 1'b0;
    last_wdata    = 32'h0F1E_2D3C;
    chk("bp_next_setup", 32'({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR}),
        32'({3'b101, 12'h020}));
    chk("bp_next_pwdata", bus.PWDATA, last_wdata);
    cyc();
    bus.PREADY = 1'b1;
    cyc();
    chk("bp_next_resp", 32'({bus.resp_valid, bus.resp_err, bus.resp_timeout}), 32'b100);
    chk("bp_next_rdata", bus.resp_rdata, 32'h0);
    bus.resp_ready = 1'b1;
    cyc();
    bus.resp_ready = 1'b0;

    // Reset in the middle of ACCESS.
    bus.req_valid = 1'b1;
    bus.req_addr  = 12'h0AA;
    bus.req_we    = 1'b1;
    bus.req_wdata = 32'h1357_9BDF;
    cyc();
    bus.req_valid = 1'b0;
    bus.PREADY    = 1'b0;
    cyc();
    chk("mid_access", 32'({bus.PSEL, bus.PENABLE}), 32'b11);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", 32'({bus.PSEL, bus.PENABLE, bus.resp_valid, bus.req_ready}), 32'b0001);
    chk("mid_rst_pwdata", bus.PWDATA, 32'h0);
    last_wdata = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    do_xfer(1'b1, 12'h0AC, 32'h2468_ACE0, 1, 1'b0, 32'h0, 0);

    // Random transfers.
    for (int t = 0; t < 25; t++) begin
      apb_req_t r;
      r.addr  = AW'($urandom);
      r.we    = 1'($urandom);
      r.wdata = $urandom;
      do_xfer(r.we, r.addr, r.wdata, int'($urandom_range(0, 5)), 1'($urandom), $urandom,
              int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Converts a simple valid/ready request/response port into single APB3 transfers, acting as the initiator (master) side of APB.
- Lets a local controller (debug unit, DMA or test sequencer) drive APB peripherals such as the GPIO, timers and UART on the peripheral bus.
- Handles one outstanding transfer at a time.
- Adds a PREADY timeout so that a hung slave cannot stall the initiator.

Parameters:
- APB_ADDR_WIDTH, 12, width of PADDR and req_addr (4KB slave window).
- TIMEOUT_CYCLES, 255, maximum ACCESS-phase cycles waiting for PREADY. 0 disables the timeout.
- CNT_WIDTH, 8, width of the timeout counter. Must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  bridge can accept a request.
- req_addr  in  APB_ADDR_WIDTH  byte address.
- req_we  in  1  1=write, 0=read.
- req_wdata  in  32  write data.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  read data (0 for writes and timeouts).
- resp_err  out  1  PSLVERR was sampled or a timeout occurred.
- resp_timeout  out  1  the transfer was aborted by timeout.
- PADDR  out  APB_ADDR_WIDTH  APB address.
- PWDATA  out  32  APB write data.
- PWRITE  out  1  APB direction.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

Behaviour:
- Clock and reset: one clock, HCLK. HRESETn is asynchronous, active-low.
- All outputs are registered or decoded directly from the state register. No combinational path from PREADY/PRDATA to the APB outputs.
- Reset values: state=IDLE; PSEL, PENABLE, PWRITE=0; PADDR, PWDATA=0; resp_valid, resp_err, resp_timeout=0; resp_rdata=0; timeout counter=0. req_ready=1 after reset.
- FSM has four states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch addr, we and wdata into PADDR, PWRITE, PWDATA; go to SETUP.
  - PWDATA is latched only when req_we=1; otherwise it is held.
- SETUP: PSEL=1, PENABLE=0, for exactly one cycle; then go to ACCESS.
- ACCESS (PSEL=1, PENABLE=1):
  - The counter increments each cycle PREADY=0.
  - On PREADY=1: capture resp_rdata = PWRITE ? 0 : PRDATA, resp_err=PSLVERR, resp_timeout=0; go to RESP.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 with PREADY=0 this cycle: go to RESP with resp_err=1, resp_timeout=1, resp_rdata=0.
  - If PREADY=1 on that same cycle, PREADY wins and the transfer is a normal completion.
- Address and data stability: PADDR, PWRITE and PWDATA stay stable from SETUP through the end of ACCESS.
- Leaving ACCESS: PSEL and PENABLE drop to 0 in RESP. The counter clears on leaving ACCESS.
- RESP:
  - resp_valid=1; resp_* data stays stable.
  - On resp_ready: resp_valid=0, go to IDLE.
  - req_ready=0 in RESP. The next request is accepted one cycle after the handshake, so there is no IDLE bypass.
- Latency: request accepted at cycle N → SETUP at N+1 → ACCESS at N+2. With zero wait states, resp_valid is asserted at N+3. Each PREADY wait cycle adds one cycle.
- Minimum transfer period is 4 cycles when resp_ready is held at 1.
- PSEL is never asserted back-to-back across transfers.
- Input changes:
  - req_* changes while req_ready=0 are ignored.
  - resp_ready while resp_valid=0 is ignored.
  - PREADY and PSLVERR are ignored outside ACCESS.
- Reset mid-transfer forces all outputs immediately to their reset values, including PSEL=0 asynchronously. The in-flight transfer is dropped and no response is produced.
- Width handling:
  - PADDR is passed through unmodified; no alignment check is made. Slaves decode PADDR[5:2] etc.
  - The counter saturates and never wraps. With TIMEOUT_CYCLES=0 the counter holds at 0.

Decomposition:
- Shared package apb_pkg holds:
  - apb_state_e (IDLE, SETUP, ACCESS, RESP).
  - An apb_req_t struct {addr, we, wdata}.
  - An apb_resp_t struct {rdata, err, timeout}.
  - The constant APB_DATA_WIDTH=32.
- The FSM, registers and counter are a single module; no sub-module is needed.
- The timeout counter is small enough to stay inline.

Test Plan:
- Write, zero wait states: req addr=0x008, wdata=0xA5A5_0F0F, slave PREADY=1 → PSEL at N+1, PENABLE at N+2, PWDATA=0xA5A5_0F0F, PWRITE=1, resp_valid at N+3, resp_err=0, resp_rdata=0.
- Read with 3 wait states: addr=0x004, PREADY low for 3 ACCESS cycles then high with PRDATA=0x1234_5678 → PENABLE high for 4 cycles, resp_rdata=0x1234_5678 at N+6, addr/ctl stable throughout.
- Slave error: read addr=0x0FC, PREADY=1, PSLVERR=1 → resp_err=1, resp_timeout=0, resp_rdata=PRDATA.
- Timeout: TIMEOUT_CYCLES=4, PREADY stuck 0 → ACCESS lasts exactly 4 cycles, then PSEL/PENABLE drop; resp_err=1, resp_timeout=1, rdata=0. Repeat with PREADY=1 on the 4th cycle → normal completion.
- Backpressure: hold resp_ready=0 for 10 cycles with req_valid=1 → response held stable, req_ready=0, no new PSEL; after resp_ready → next SETUP 2 cycles after the handshake.
- Reset mid-ACCESS: assert HRESETn=0 while PENABLE=1 → PSEL/PENABLE=0 immediately, resp_valid=0; after release req_ready=1 and a new write completes normally.
